// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter sizing shared by the serial adder.
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);
   assign sum       = a ^ b ^ carry_in;
   assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit per cycle, valid/ready on both sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);
   localparam int CW = cnt_width(WIDTH);
   state_e state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic c_q, c_d, fa_s, fa_c;
   logic [CW-1:0] cnt_q, cnt_d;
   full_adder u_fa (
      .a        (a_q[0]),
      .b        (b_q[0]),
      .carry_in (c_q),
      .sum      (fa_s),
      .carry_out(fa_c)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = a;
            b_d     = b;
            c_d     = carry_in;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            c_d     = fa_c;
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
         end
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
      end
   end
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q == RUN;
   assign sum       = sum_q;
   assign carry_out = c_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   logic       iv8, ir8, ci8, ov8, or8, co8, bz8;
   logic [7:0] a8, b8, s8;
   logic       iv1, ir1, ci1, ov1, or1, co1, bz1;
   logic [0:0] a1, b1, s1;
   int total = 0;
   int bad = 0;
   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .carry_in(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .carry_out(co8), .busy(bz8)
   );
   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .carry_in(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1), .busy(bz1)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      int n = 0;
      while (!ir8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("start_ready", ir8, 1'b1);
      a8 = a; b8 = b; ci8 = ci; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
   endtask
   task automatic wait_done8(input string tag, input int exp_lat);
      int n = 0;
      while (!ov8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, exp_lat);
   endtask
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec);
      start8(a, b, ci);
      wait_done8(tag, 8);
      chk({tag, "_sum"}, s8, es);
      chk({tag, "_co"}, co8, ec);
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      chk({tag, "_rdy_after"}, ir8, 1'b1);
      chk({tag, "_ov_after"}, ov8, 1'b0);
   endtask
   initial begin
      logic any_ov;
      int n;
      rst_n = 1'b0;
      {iv8, ci8, or8, iv1, ci1, or1} = '0;
      a8 = '0; b8 = '0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_ir8", ir8, 1'b1);
      chk("rst_ov8", ov8, 1'b0);
      chk("rst_bz8", bz8, 1'b0);
      chk("rst_sum8", s8, 8'h00);
      chk("rst_co8", co8, 1'b0);
      chk("rst_ir1", ir1, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      start8(8'h35, 8'h4A, 1'b0);
      chk("basic_busy", bz8, 1'b1);
      chk("basic_ir_run", ir8, 1'b0);
      wait_done8("basic", 8);
      chk("basic_sum", s8, 8'h7F);
      chk("basic_co", co8, 1'b0);
      chk("basic_bz_done", bz8, 1'b0);
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      chk("basic_ir_after", ir8, 1'b1);
      op8("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op8("ffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      start8(8'h12, 8'h34, 1'b1);
      wait_done8("hold", 8);
      for (int i = 0; i < 5; i++) begin
         iv8 = i[0]; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
         @(negedge clk);
         chk("hold_ov", ov8, 1'b1);
         chk("hold_ir", ir8, 1'b0);
         chk("hold_sum", s8, 8'h47);
         chk("hold_co", co8, 1'b0);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      @(negedge clk);
      chk("hold_no_capture", bz8, 1'b0);
      start8(8'h55, 8'h0F, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ir", ir8, 1'b1);
      chk("mid_rst_ov", ov8, 1'b0);
      chk("mid_rst_bz", bz8, 1'b0);
      chk("mid_rst_sum", s8, 8'h00);
      chk("mid_rst_co", co8, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      any_ov = 1'b0;
      repeat (12) begin
         @(negedge clk);
         any_ov |= ov8;
      end
      chk("mid_rst_no_ov", any_ov, 1'b0);
      op8("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
      a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
      @(negedge clk);
      chk("b2b_busy1", bz8, 1'b1);
      wait_done8("b2b1", 8);
      chk("b2b1_sum", s8, 8'h30);
      chk("b2b1_co", co8, 1'b0);
      a8 = 8'h0F; b8 = 8'hF0; ci8 = 1'b1;
      @(negedge clk);
      chk("b2b_ir_back", ir8, 1'b1);
      chk("b2b_ov_low", ov8, 1'b0);
      @(negedge clk);
      chk("b2b_busy2", bz8, 1'b1);
      iv8 = 1'b0; or8 = 1'b0;
      wait_done8("b2b2", 8);
      chk("b2b2_sum", s8, 8'h00);
      chk("b2b2_co", co8, 1'b1);
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      chk("w1_busy", bz1, 1'b1);
      n = 0;
      while (!ov1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("w1_lat", n, 1);
      chk("w1_sum", s1, 1'b1);
      chk("w1_co", co1, 1'b1);
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
      chk("w1_ir_after", ir1, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port carry_in  input  1  initial carry.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  result sum bits.
REQ-012 SHALL have port carry_out  output  1  final carry of the WIDTH-bit add.
REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in RUN.
REQ-016 In IDLE, on in_valid&&in_ready SHALL capture a, b, carry_in into shift/carry registers, clear bit counter, go to RUN.
REQ-017 In RUN, each cycle SHALL add one bit LSB-first: a_sh[0], b_sh[0], carry register -> sum bit shifted into sum register from the MSB side, carry register updated, a_sh/b_sh shifted right, counter incremented.
REQ-018 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; out_valid rises exactly WIDTH cycles after the accepting edge (WIDTH=1: one cycle).
REQ-019 sum SHALL equal (a+b+carry_in) mod 2^WIDTH and carry_out bit WIDTH of that sum, both stable throughout DONE.
REQ-020 In DONE, SHALL hold outputs until out_valid&&out_ready, then return to IDLE; in_ready rises the following cycle (no same-cycle bypass).
REQ-021 in_valid, a, b, carry_in SHALL be ignored outside IDLE; out_ready ignored outside DONE.
REQ-022 sum/carry_out SHALL be meaningful only while out_valid=1; they may change during RUN.
REQ-023 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and never wrap within an operation.

Reset
REQ-024 rst_n low SHALL, asynchronously and at any state (including mid-RUN or DONE), force IDLE and clear all registers: sum=0, carry_out=0, out_valid=0, busy=0, in_ready=1.
REQ-025 An operation interrupted by reset SHALL be discarded with no out_valid pulse.

Structure
REQ-026 FSM state typedef and state encodings SHALL live in shared package serial_adder_pkg.
REQ-027 Per-bit addition SHALL instantiate the team's existing full_adder cell (ports a, b, carry_in, sum, carry_out); no other sub-modules.
REQ-028 All outputs SHALL be driven from registers or decoded state only (no input-to-output combinational path).

Verification
REQ-029 WIDTH=8, a=0x35, b=0x4A, carry_in=0 -> sum=0x7F, carry_out=0, out_valid exactly 8 cycles after accept.
REQ-030 a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1; a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
REQ-031 out_ready held low 5 cycles in DONE with in_valid pulsing -> sum/carry_out stable, in_ready=0, no new capture.
REQ-032 rst_n pulsed low during RUN after bit 3 -> all outputs at reset values, IDLE; then a=0x01, b=0x02, carry_in=0 -> sum=0x03, carry_out=0.
REQ-033 in_valid held high with out_ready=1 -> result handshakes, in_ready returns one cycle later, second operand pair accepted, result correct.
REQ-034 WIDTH=1, a=1, b=1, carry_in=1 -> sum=1, carry_out=1, out_valid one cycle after accept.
